regfile_wb_sequencer: RTL and testbench

Write-side front end for the 32x32 register file. Accepts writeback results from the ALU and load paths, buffers them in a small FIFO, and drains them one per cycle onto the register file write port (`RegWrite`/`A3`/`WD3`). When a read slot is requested, it holds `RegWrite` low for that cycle, because the register file only samples `RD1`/`RD2` on non-write cycles. Writes to `$0` are silently discarded.

---
 rtl/mips_pkg.sv | 13 +
 rtl/wb_fifo.sv | 75 +++++++
 rtl/regfile_wb_sequencer.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback entry type.
package mips_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered count/full/empty.
// With WB_FORWARD_EN defined, entries are exposed oldest-first for bypass search.
module wb_fifo
  import mips_pkg::*;
#(
  parameter type         T     = wb_entry_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_entry,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef WB_FORWARD_EN
  ,
  output T                       slot [DEPTH],
  output logic [DEPTH-1:0]       slot_valid
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  T            mem [DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  logic        do_push;
  logic        do_pop;
  logic [PW:0] count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (!do_push && do_pop) count_next = count - 1'b1;
  end

  // Status flags are registered from the next count so they never see a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot[i]       = mem[rd_ptr + ptr_t'(i)];
      slot_valid[i] = ((PW+1)'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Register-file write-side front end: load/ALU arbitration, $0 filter, FIFO drain, read slots.
// Optional combinational bypass enabled by defining WB_FORWARD_EN.
module regfile_wb_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_data,
  input  logic                   rd_req,
  output logic                   RegWrite,
  output logic [AW-1:0]          A3,
  output logic [DW-1:0]          WD3,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef WB_FORWARD_EN
  ,
  input  logic [AW-1:0]          fwd_addr1,
  input  logic [AW-1:0]          fwd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data1,
  output logic [DW-1:0]          fwd_data2
`endif
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic   mem_fire;
  logic   alu_fire;
  logic   push;
  logic   pop;
  entry_t in_entry;
  entry_t head;

  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  always_comb begin
    in_entry = mem_fire ? '{addr: mem_addr, data: mem_data} : '{addr: alu_addr, data: alu_data};
  end

  // $0 writes complete their handshake but never occupy a slot.
  assign push = (mem_fire || alu_fire) && (in_entry.addr != ZERO_ADDR);
  assign pop  = !empty && !rd_req;

`ifdef WB_FORWARD_EN
  entry_t           slot [DEPTH];
  logic [DEPTH-1:0] slot_valid;
`endif

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef WB_FORWARD_EN
    ,
    .slot       (slot),
    .slot_valid (slot_valid)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        A3  <= head.addr;
        WD3 <= head.data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic [AW-1:0] f_addr [2];
  logic          f_hit  [2];
  logic [DW-1:0] f_data [2];

  assign f_addr[0] = fwd_addr1;
  assign f_addr[1] = fwd_addr2;

  // Output register is older than every FIFO entry; later matches overwrite earlier ones.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      f_hit[p]  = 1'b0;
      f_data[p] = '0;
      if (RegWrite && (A3 == f_addr[p])) begin
        f_hit[p]  = 1'b1;
        f_data[p] = WD3;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (slot_valid[i] && (slot[i].addr == f_addr[p])) begin
          f_hit[p]  = 1'b1;
          f_data[p] = slot[i].data;
        end
      end
      if (f_addr[p] == ZERO_ADDR) begin
        f_hit[p]  = 1'b0;
        f_data[p] = '0;
      end
    end
  end

  assign fwd_hit1  = f_hit[0];
  assign fwd_hit2  = f_hit[1];
  assign fwd_data1 = f_data[0];
  assign fwd_data2 = f_data[1];
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed self-checking bench for regfile_wb_sequencer (WB_FORWARD_EN checks when defined).
module tb_regfile_wb_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          rd_req = 1'b0;
  logic          RegWrite;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [2:0]    count;
  logic          full;
  logic          empty;
`ifdef WB_FORWARD_EN
  logic [AW-1:0] fwd_addr1 = '0;
  logic [AW-1:0] fwd_addr2 = '0;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [AW+DW-1:0] seen [$];

  regfile_wb_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .rd_req    (rd_req),
    .RegWrite  (RegWrite),
    .A3        (A3),
    .WD3       (WD3),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && RegWrite === 1'b1) seen.push_back({A3, WD3});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    alu_valid = 1'b0; mem_valid = 1'b0; rd_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic is_mem, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    if (is_mem) begin mem_valid = 1'b1; mem_addr = a; mem_data = d; end
    else begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
    #1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      ok = is_mem ? mem_ready : alu_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    if (!ok) begin n_cmp++; n_err++; $display("FAIL send_timeout: addr %0d never accepted", a); end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (empty === 1'b1 && RegWrite === 1'b0) begin idle = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!idle) begin n_cmp++; n_err++; $display("FAIL drain_timeout: count=%0d RegWrite=%b", count, RegWrite); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_cmp++; if (A3 !== 5'd0) begin n_err++; $display("FAIL reset_a3: got %h want 0", A3); end
    n_cmp++; if (WD3 !== 32'd0) begin n_err++; $display("FAIL reset_wd3: got %h want 0", WD3); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL post_reset_regwrite: got %b want 0", RegWrite); end
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_early_rw: got %b want 0", RegWrite); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", empty); end
    @(posedge clk); #1;
    n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_rw: got %b want 1", RegWrite); end
    n_cmp++; if (A3 !== 5'd5) begin n_err++; $display("FAIL single_a3: got %0d want 5", A3); end
    n_cmp++; if (WD3 !== 32'h1234_5678) begin n_err++; $display("FAIL single_wd3: got %h want 12345678", WD3); end
    @(posedge clk); #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_rw_drop: got %b want 0", RegWrite); end
    n_cmp++; if (A3 !== 5'd5) begin n_err++; $display("FAIL single_a3_hold: got %0d want 5", A3); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_priority();
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h0000_AAAA;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_BBBB;
    #1;
    n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_alu_ready: got %b want 0", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL prio_mem_ready: got %b want 1", mem_ready); end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_ready2: got %b want 1", alu_ready); end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    n_cmp++; if ({RegWrite, A3, WD3} !== {1'b1, 5'd3, 32'h0000_AAAA}) begin n_err++; $display("FAIL prio_first: got rw=%b a3=%0d wd3=%h want rw=1 a3=3 wd3=0000aaaa", RegWrite, A3, WD3); end
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, A3, WD3} !== {1'b1, 5'd4, 32'h0000_BBBB}) begin n_err++; $display("FAIL prio_second: got rw=%b a3=%0d wd3=%h want rw=1 a3=4 wd3=0000bbbb", RegWrite, A3, WD3); end
    @(posedge clk); #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL prio_end: got %b want 0", RegWrite); end
  endtask

  task automatic test_zero_discard();
    logic rose;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_DEAD;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", alu_ready); end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL zero_empty: got %b want 1", empty); end
`ifdef WB_FORWARD_EN
    fwd_addr1 = 5'd0;
    #1;
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("FAIL zero_fwd_hit: got %b want 0", fwd_hit1); end
`endif
    rose = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (RegWrite !== 1'b0) rose = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (rose !== 1'b0) begin n_err++; $display("FAIL zero_regwrite: got rise=%b want 0", rose); end
  endtask

  task automatic test_full_wrap();
    logic [AW+DW-1:0] want;
    logic [AW+DW-1:0] got;
    seen.delete();
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i + 1), DW'(32'hC0DE_0000 + i));
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL wrap_full: got %b want 1", full); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", count); end
    n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL wrap_alu_ready: got %b want 0", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL wrap_mem_ready: got %b want 0", mem_ready); end
    n_cmp++; if (seen.size() != 0) begin n_err++; $display("FAIL wrap_stalled: got %0d writes want 0", seen.size()); end
    rd_req = 1'b0;
    for (int i = 4; i < 10; i++) send(i[0], AW'(i + 1), DW'(32'hC0DE_0000 + i));
    wait_idle();
    n_cmp++; if (seen.size() != 10) begin n_err++; $display("FAIL wrap_total: got %0d writes want 10", seen.size()); end
    for (int i = 0; i < 10; i++) begin
      want = {AW'(i + 1), DW'(32'hC0DE_0000 + i)};
      got  = (i < seen.size()) ? seen[i] : 'x;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_read_slot();
    rd_req = 1'b1;
    send(1'b0, 5'd10, 32'h0000_00A0);
    send(1'b1, 5'd11, 32'h0000_00A1);
    send(1'b0, 5'd12, 32'h0000_00A2);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL slot_count: got %0d want 3", count); end
    rd_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, A3, WD3} !== {1'b1, 5'd10, 32'h0000_00A0}) begin n_err++; $display("FAIL slot_w0: got rw=%b a3=%0d wd3=%h want rw=1 a3=10 wd3=a0", RegWrite, A3, WD3); end
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    n_cmp++; if ({RegWrite, A3} !== {1'b0, 5'd10}) begin n_err++; $display("FAIL slot_gap: got rw=%b a3=%0d want rw=0 a3=10", RegWrite, A3); end
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, A3, WD3} !== {1'b1, 5'd11, 32'h0000_00A1}) begin n_err++; $display("FAIL slot_w1: got rw=%b a3=%0d wd3=%h want rw=1 a3=11 wd3=a1", RegWrite, A3, WD3); end
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, A3, WD3} !== {1'b1, 5'd12, 32'h0000_00A2}) begin n_err++; $display("FAIL slot_w2: got rw=%b a3=%0d wd3=%h want rw=1 a3=12 wd3=a2", RegWrite, A3, WD3); end
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, empty} !== 2'b01) begin n_err++; $display("FAIL slot_end: got rw=%b empty=%b want rw=0 empty=1", RegWrite, empty); end
  endtask

  task automatic test_async_reset();
    rd_req = 1'b1;
    send(1'b0, 5'd20, 32'h0000_0020);
    send(1'b0, 5'd21, 32'h0000_0021);
    rd_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL arst_pre_rw: got %b want 1", RegWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({RegWrite, A3, count, empty} !== {1'b0, 5'd0, 3'd0, 1'b1}) begin n_err++; $display("FAIL arst_clear: got rw=%b a3=%0d count=%0d empty=%b want 0 0 0 1", RegWrite, A3, count, empty); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, empty} !== 2'b01) begin n_err++; $display("FAIL arst_lost: got rw=%b empty=%b want rw=0 empty=1", RegWrite, empty); end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    rd_req = 1'b1;
    send(1'b0, 5'd7, 32'd1);
    send(1'b0, 5'd7, 32'd2);
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd8;
    #1;
    n_cmp++; if ({fwd_hit1, fwd_data1} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL fwd_newest: got hit=%b data=%h want hit=1 data=2", fwd_hit1, fwd_data1); end
    n_cmp++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_miss: got %b want 0", fwd_hit2); end
    rd_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({RegWrite, fwd_hit1, fwd_data1} !== {1'b1, 1'b1, 32'd2}) begin n_err++; $display("FAIL fwd_split: got rw=%b hit=%b data=%h want 1 1 2", RegWrite, fwd_hit1, fwd_data1); end
    @(posedge clk); #1;
    n_cmp++; if ({fwd_hit1, fwd_data1} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL fwd_outreg: got hit=%b data=%h want hit=1 data=2", fwd_hit1, fwd_data1); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("FAIL fwd_drained: got %b want 0", fwd_hit1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    do_reset();
    test_priority();
    do_reset();
    test_zero_discard();
    do_reset();
    test_full_wrap();
    do_reset();
    test_read_slot();
    do_reset();
    test_async_reset();
`ifdef WB_FORWARD_EN
    do_reset();
    test_forward();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
